// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives comparator A and bisects
// on the lt/gt/eq flags until the comparator's B value is located.
module sar_search_ctrl #(
   parameter int WIDTH  = 17,
   parameter int SETTLE = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic [WIDTH-1:0]             guess,
   input  logic                         cmp_lt,
   input  logic                         cmp_gt,
   input  logic                         cmp_eq,
   output logic                         busy,
   output logic                         done,
   output logic                         found,
   output logic                         err,
   output logic [WIDTH-1:0]             result,
   output logic [$clog2(WIDTH+2)-1:0]   probes
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EVAL, S_DONE} state_t;
   localparam state_t S_PROBE = (SETTLE == 0) ? S_EVAL : S_SETTLE;

   state_t           state;
   logic [WIDTH:0]   lo, hi, lo_nx, hi_nx;
   logic             empty_nx, flags_ok;
   logic [WIDTH-1:0] guess_nx;
   logic [CW-1:0]    cnt;

   // hi is two's complement in WIDTH+1 bits: bit WIDTH set means it went below 0.
   // lo never exceeds 2^WIDTH, so an unsigned compare is safe once hi >= 0.
   always_comb begin
      lo_nx = lo;
      hi_nx = hi;
      if (cmp_lt) lo_nx = {1'b0, guess} + 1'b1;
      else        hi_nx = {1'b0, guess} - 1'b1;
      empty_nx = hi_nx[WIDTH] || (lo_nx > hi_nx);
      guess_nx = WIDTH'(lo_nx + ((hi_nx - lo_nx) >> 1));
      flags_ok = $onehot({cmp_lt, cmp_gt, cmp_eq});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         guess  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         found  <= 1'b0;
         err    <= 1'b0;
         result <= '0;
         probes <= '0;
         lo     <= '0;
         hi     <= {1'b0, {WIDTH{1'b1}}};
         cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  lo     <= '0;
                  hi     <= {1'b0, {WIDTH{1'b1}}};
                  guess  <= {1'b0, {(WIDTH-1){1'b1}}};
                  probes <= '0;
                  found  <= 1'b0;
                  err    <= 1'b0;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  state  <= S_PROBE;
               end
            end
            S_SETTLE: begin
               if (cnt == CW'(SETTLE - 1)) state <= S_EVAL;
               else                        cnt   <= cnt + 1'b1;
            end
            S_EVAL: begin
               probes <= probes + 1'b1;
               if (!flags_ok) begin
                  err   <= 1'b1;
                  found <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (cmp_eq) begin
                  result <= guess;
                  found  <= 1'b1;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  lo <= lo_nx;
                  hi <= hi_nx;
                  if (empty_nx) begin
                     found  <= 1'b0;
                     result <= '0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     guess <= guess_nx;
                     cnt   <= '0;
                     state <= S_PROBE;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: bench-side comparator plus an integer bisection
// model that predicts the guess sequence, outcome and timing of each search.
module tb_sar_search_ctrl;
   localparam int W  = 17;
   localparam int ST = 1;
   localparam int PW = $clog2(W + 2);

   logic          clk = 1'b0;
   logic          rst, start;
   logic [W-1:0]  guess, result;
   logic          cmp_lt, cmp_gt, cmp_eq;
   logic          busy, done, found, err;
   logic [PW-1:0] probes;

   int            n_cmp = 0, n_bad = 0;
   int            mode;          // 0 honest, 1 always gt, 2 illegal flags on one guess
   logic [W-1:0]  tgt, bad;

   int            exp_q[$];
   int            exp_p, exp_res;
   bit            exp_found, exp_err;

   sar_search_ctrl #(.WIDTH(W), .SETTLE(ST)) dut (
      .clk(clk), .rst(rst), .start(start), .guess(guess),
      .cmp_lt(cmp_lt), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq),
      .busy(busy), .done(done), .found(found), .err(err),
      .result(result), .probes(probes)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (mode == 1)                      {cmp_lt, cmp_gt, cmp_eq} = 3'b010;
      else if (mode == 2 && guess == bad) {cmp_lt, cmp_gt, cmp_eq} = 3'b110;
      else begin
         cmp_lt = guess < tgt;
         cmp_gt = guess > tgt;
         cmp_eq = guess == tgt;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Plain integer bisection over [0, 2^W-1]; illegal flags in mode 2 hit the 3rd probe.
   task automatic model(input int t, input int m);
      int lo, hi, g;
      lo = 0; hi = (1 << W) - 1;
      exp_q.delete();
      exp_found = 0; exp_err = 0; exp_res = -1; exp_p = 0;
      forever begin
         g = lo + (hi - lo) / 2;
         exp_q.push_back(g);
         exp_p++;
         if (m == 2 && exp_p == 3) begin exp_err = 1; break; end
         if (m != 1 && g == t) begin exp_found = 1; exp_res = g; break; end
         if (m != 1 && g < t) lo = g + 1;
         else                 hi = g - 1;
         if (lo > hi) begin exp_res = 0; break; end
      end
   endtask

   // Caller guarantees the DUT is in IDLE; hold keeps start high afterwards.
   task automatic run_search(input int t, input int m, input bit hold);
      int obs[$];
      int bc, dn;
      if (m == 2) begin
         model(t, 0);
         bad = W'(exp_q[2]);
      end
      model(t, m);
      tgt = W'(t); mode = m;
      start = 1'b1;
      @(posedge clk);
      bc = 0; dn = 0;
      for (int n = 1; n <= 80; n++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         if (done) begin dn = n; break; end
         if (busy) bc++;
         if (n % 2 == 0) obs.push_back(int'(guess));
      end
      if (dn == 0) begin
         chk("done_timeout", 0, 1);
         return;
      end
      chk("done_cycle", 64'(dn), 64'(exp_p * (ST + 1) + 1));
      chk("busy_cycles", 64'(bc), 64'(exp_p * (ST + 1)));
      chk("busy_at_done", 64'(busy), 0);
      chk("found", 64'(found), 64'(exp_found));
      chk("err", 64'(err), 64'(exp_err));
      chk("probes", 64'(probes), 64'(exp_p));
      if (!exp_err) chk("result", 64'(result), 64'(exp_res));
      chk("n_guesses", 64'(obs.size()), 64'(exp_q.size()));
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
         chk("guess_seq", 64'(obs[i]), 64'(exp_q[i]));
      @(negedge clk);
      chk("done_pulse_end", 64'(done), 0);
      chk("idle_gap_busy", 64'(busy), 0);
   endtask

   initial begin
      int dcount;
      rst = 1'b1; start = 1'b0; mode = 0; tgt = '0; bad = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_guess", 64'(guess), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_found", 64'(found), 0);
      chk("rst_err", 64'(err), 0);
      chk("rst_result", 64'(result), 0);
      chk("rst_probes", 64'(probes), 0);
      rst = 1'b0;
      @(negedge clk);

      run_search(0, 0, 0);
      run_search((1 << W) - 1, 0, 0);
      run_search(11, 0, 0);
      run_search(10, 0, 0);
      run_search(65535, 0, 0);
      run_search(int'($urandom_range(0, (1 << W) - 1)), 1, 0);
      run_search(int'($urandom_range(0, 30000)), 2, 0);

      // reset in the middle of a search: abort with no done pulse
      tgt = W'(5000); mode = 0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      dcount = 0;
      for (int n = 2; n <= 5; n++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 0);
      chk("midrst_guess", 64'(guess), 0);
      chk("midrst_probes", 64'(probes), 0);
      chk("midrst_done", 64'(done), 0);
      rst = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("midrst_no_done", 64'(dcount), 0);
      run_search(11, 0, 0);

      for (int i = 0; i < 20; i++)
         run_search(int'($urandom_range(0, (1 << W) - 1)), 0, 0);

      // start held high: each search follows the previous after one IDLE cycle
      for (int i = 0; i < 3; i++)
         run_search(int'($urandom_range(0, (1 << W) - 1)), 0, 1);
      start = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Binary-search (successive-approximation) controller that drives the A operand of an external nbit_comparator and reads back its lt/gt/eq flags.
- Converges on the unknown value presented on the comparator's B input.
- Sits on the initiator side of the comparator interface and replaces software/bench stepping of A with a clocked FSM.
- Reports the found value, the probe count, and error conditions.

Parameters:
- WIDTH, 17, operand width; must match the comparator's A/B width.
- SETTLE, 1, idle cycles after each guess change before the flags are sampled (≥0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a search; sampled only in IDLE
- guess  out  WIDTH  value driven to comparator A
- cmp_lt  in  1  comparator flag: guess < target
- cmp_gt  in  1  comparator flag: guess > target
- cmp_eq  in  1  comparator flag: guess == target
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the search ends
- found  out  1  valid with done, held until the next start; target located
- err  out  1  valid with done, held; illegal flag combination sampled
- result  out  WIDTH  located value; held until the next start
- probes  out  $clog2(WIDTH+2)  number of evaluations made; held

Behaviour:
- Reset (sync, rst=1 at an edge), regardless of state: state=IDLE; guess=0; busy=0; done=0; found=0; err=0; result=0; probes=0; lo=0; hi=2^WIDTH-1.
- lo and hi are WIDTH+1 bits wide internally so that under/overflow is detectable.
- Next-guess computation: guess = lo + ((hi-lo)>>1), truncated to WIDTH bits.
- IDLE:
  - start=1 → lo=0, hi=2^WIDTH-1, guess=2^(WIDTH-1)-1, probes=0, found=0, err=0, busy=1.
  - Then go to SETTLE, or to EVAL if SETTLE=0.
  - start while not IDLE is ignored.
- SETTLE: count SETTLE cycles with guess stable, then go to EVAL.
- EVAL: sample the flags once, probes += 1.
  - Exactly one of lt/gt/eq high, eq → result=guess, found=1, go to DONE.
  - Exactly one high, lt → lo=guess+1.
  - Exactly one high, gt → hi=guess-1, computed signed in WIDTH+1 bits.
  - After an lt/gt update, if lo>hi (including hi<0 or lo>2^WIDTH-1) → found=0, result=0, go to DONE.
  - Otherwise load the new guess and go to SETTLE/EVAL.
  - Zero flags or more than one flag high → err=1, found=0, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle; next state IDLE. guess holds its last value.
- Cost per probe: SETTLE+1 cycles.
- Maximum probes: WIDTH+1.
- Worst-case latency from the start edge to done: (WIDTH+1)·(SETTLE+1)+1 cycles.
- start asserted in the same cycle as done (DONE state) is ignored; it is accepted one cycle later in IDLE if still high.
- rst asserted mid-search aborts immediately with no done pulse.

Test Plan:
- Bench uses WIDTH=17, SETTLE=1, and a bench-modelled comparator that responds combinationally.
- Target 0 → guess sequence 65535, 32767, …, 1, 0; done with found=1, result=0, probes=17, err=0; busy high for 34 cycles.
- Target 131071 → guesses 65535, 98303, …, 131070, 131071; found=1, result=131071, probes=18, the worst case.
- Targets 11, 10, 65535 → found=1 with the matching result. For 65535: probes=1, done 3 cycles after start.
- Comparator forced to always report gt → after guess 0, hi underflows; done with found=0, err=0, result=0, probes=17.
- Flags forced to lt=gt=1 on the 3rd probe → done with err=1, found=0, probes=3.
- rst pulsed on the 5th cycle of a search → next edge gives busy=0, guess=0, probes=0, and no done pulse. A following start with target 11 completes normally.
- start held high continuously → searches back-to-back, separated by exactly one IDLE cycle after each done.
